// File: rtl/cla_seq_pkg.sv
// Shared constants and FSM state encoding for the nibble-serial CLA adder.
package cla_seq_pkg;

    localparam int unsigned NIBBLES_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/cla4.sv
// 4-bit carry-lookahead adder slice: all carries resolved from generate/propagate terms.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s = p ^ c;

endmodule

// File: rtl/cla_seq8.sv
// Multi-nibble adder time-sharing one cla4 slice, LSB nibble first.
// Optional subtract mode is enabled with `define CLA_SEQ8_SUB_EN.
module cla_seq8
    import cla_seq_pkg::*;
#(
    parameter int unsigned NIBBLES = NIBBLES_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
`ifdef CLA_SEQ8_SUB_EN
    input  logic                   sub,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   co
);

    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_t           state_q, state_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic             carry_q, carry_n;
    logic [W-1:0]     a_q, a_n;
    logic [W-1:0]     b_q, b_n;
    logic [W-1:0]     sum_n;
    logic             co_n, busy_n, done_n;

    logic [3:0]       slice_s;
    logic             slice_co;

    cla4 u_cla4 (
        .a  (a_q[{idx_q, 2'b00} +: 4]),
        .b  (b_q[{idx_q, 2'b00} +: 4]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum     <= '0;
            co      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            carry_q <= carry_n;
            a_q     <= a_n;
            b_q     <= b_n;
            sum     <= sum_n;
            co      <= co_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    // Next-state and datapath updates; only the active nibble of sum is rewritten.
    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        carry_n = carry_q;
        a_n     = a_q;
        b_n     = b_q;
        sum_n   = sum;
        co_n    = co;
        busy_n  = 1'b0;
        done_n  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_n     = op_a;
`ifdef CLA_SEQ8_SUB_EN
                    b_n     = op_b ^ {W{sub}};
                    carry_n = sub;
`else
                    b_n     = op_b;
                    carry_n = 1'b0;
`endif
                    idx_n   = '0;
                    state_n = RUN;
                    busy_n  = 1'b1;
                end
            end
            RUN: begin
                busy_n = 1'b1;
                sum_n[{idx_q, 2'b00} +: 4] = slice_s;
                carry_n = slice_co;
                if (idx_q == IDX_LAST) begin
                    co_n    = slice_co;
                    done_n  = 1'b1;
                    state_n = DONE;
                end else begin
                    idx_n = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cla_seq8.sv
// Scoreboard bench for cla_seq8: directed vectors, timing, ignored start, mid-run reset.
module tb_cla_seq8;

    localparam int unsigned N = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
`ifdef CLA_SEQ8_SUB_EN
    logic        sub;
`endif
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic        co;

    int checks   = 0;
    int failures = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;

    cla_seq8 #(.NIBBLES(N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
`ifdef CLA_SEQ8_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .co    (co)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done with sum=%0h, required no done", sum);
            end else begin
                mon_e = exp_q.pop_front();
                check("sum", {32'h0, sum}, {32'h0, mon_e[31:0]});
                check("co", {63'h0, co}, {63'h0, mon_e[32]});
            end
        end
    end

    // Called at a negedge; drives start, then measures done latency and busy length.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_s, input logic exp_co, input bit inject);
        int cyc, busy_cnt, done_cyc, done_cnt;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        exp_q.push_back({exp_co, exp_s});
        @(negedge clk);
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
        cyc = 0; busy_cnt = 0; done_cyc = -1; done_cnt = 0;
        while (cyc < 40) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && !busy) break;
            if (inject && cyc == 3) begin
                start = 1'b1;
                op_a  = 32'hF000_0000;
                op_b  = 32'hF000_0000;
            end
            if (inject && cyc == 4) start = 1'b0;
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        check({name, " done_cycle"}, 64'(done_cyc), 64'(N));
        check({name, " busy_cycles"}, 64'(busy_cnt), 64'(N + 1));
        check({name, " done_pulses"}, 64'(done_cnt), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
`ifdef CLA_SEQ8_SUB_EN
        sub   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", {63'h0, busy}, 64'h0);
        check("reset done", {63'h0, done}, 64'h0);
        check("reset sum", {32'h0, sum}, 64'h0);
        check("reset co", {63'h0, co}, 64'h0);
        reset = 1'b0;

        run_op("carry_ripple", 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        run_op("digits", 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0);
        run_op("back_to_back", 32'h0000_000F, 32'h0000_0001, 32'h0000_0010, 1'b0, 1'b0);
        run_op("ignored_start", 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b1);
        run_op("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0);
        run_op("msb_carry", 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0);

        // Abort mid-run: outputs clear asynchronously and no done follows.
        op_a  = 32'h1111_1111;
        op_b  = 32'h1111_1111;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        check("abort busy", {63'h0, busy}, 64'h0);
        check("abort done", {63'h0, done}, 64'h0);
        check("abort sum", {32'h0, sum}, 64'h0);
        check("abort co", {63'h0, co}, 64'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);

        run_op("after_reset", 32'h0000_000A, 32'h0000_0005, 32'h0000_000F, 1'b0, 1'b0);

`ifdef CLA_SEQ8_SUB_EN
        sub = 1'b1;
        run_op("sub_borrow", 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("sub_noborrow", 32'h0000_0007, 32'h0000_0005, 32'h0000_0002, 1'b1, 1'b0);
        sub = 1'b0;
        run_op("sub_off_add", 32'h0000_0007, 32'h0000_0005, 32'h0000_000C, 1'b0, 1'b0);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cla_seq8.md
CLA_SEQ8 -- requirements
Module: cla_seq8

Interface
REQ-001 Parameter NIBBLES, default 8: operand width is 4*NIBBLES bits; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 op_a  input  4*NIBBLES  augend, captured on accepted start.
REQ-006 op_b  input  4*NIBBLES  addend or subtrahend, captured on accepted start.
REQ-007 sub  input  1  1 = compute op_a - op_b; port present only when SUB_EN is defined.
REQ-008 busy  output  1  high in RUN and DONE states.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 sum  output  4*NIBBLES  result, held stable from done until the next accepted start.
REQ-011 co  output  1  final carry out of the most significant nibble, held with sum.

Function
REQ-012 The block SHALL perform a 4*NIBBLES-bit add by time-sharing one 4-bit carry-lookahead slice, one nibble per cycle, LSB nibble first.
REQ-013 FSM states SHALL be IDLE, RUN, DONE.
REQ-014 IDLE: start=1 SHALL capture op_a/op_b (and sub), set nibble index to 0, load carry register with 0 (or with sub under SUB_EN), and go to RUN; start=0 stays in IDLE.
REQ-015 RUN: each cycle the slice SHALL add nibble[idx] of the captured operands with carry register as ci, write the 4-bit result into sum nibble[idx], load slice co into the carry register, increment idx.
REQ-016 RUN SHALL go to DONE in the cycle idx = NIBBLES-1 completes; idx SHALL NOT wrap past NIBBLES-1.
REQ-017 DONE: done=1 for exactly one cycle, co = carry register, then unconditional return to IDLE.
REQ-018 Latency: start accepted at edge t -> done high in the cycle after edge t+NIBBLES; next start accepted at the first edge after done falls (back-to-back throughput NIBBLES+2 cycles).
REQ-019 start while busy=1 SHALL be ignored with no effect on captured operands or result.
REQ-020 Upper nibbles of sum SHALL NOT be modified before their RUN cycle; sum and co SHALL only be observed as valid at done.
REQ-021 Operand inputs changing after the accept edge SHALL NOT affect the result.

Reset
REQ-022 reset=1 SHALL asynchronously force state IDLE, idx=0, carry=0, sum=0, co=0, busy=0, done=0, including mid-RUN; the aborted operation SHALL produce no done pulse.
REQ-023 After reset deasserts, the first start SHALL be accepted normally.

Configuration
REQ-024 Macro CLA_SEQ8_SUB_EN: when defined, sub port exists; on sub=1 every op_b nibble SHALL be inverted before the slice and initial carry SHALL be 1 (two's-complement subtract; co=1 means no borrow).
REQ-025 Without CLA_SEQ8_SUB_EN: no sub port, no inverter logic, initial carry always 0.

Structure
REQ-026 Package cla_seq_pkg SHALL hold the state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the NIBBLES default constant.
REQ-027 Exactly one sub-module instance: cla4 (4-bit carry-lookahead adder: a, b, ci -> s, co); no other adder logic in this block.

Verification
REQ-028 NIBBLES=8: op_a=0x00000001, op_b=0xFFFFFFFF, start at edge t -> sum=0x00000000, co=1, done high exactly after edge t+8, busy high 9 cycles.
REQ-029 op_a=0x12345678, op_b=0x11111111 -> sum=0x23456789, co=0; a second start on the cycle after done yields 0x0000000F+0x00000001 -> sum=0x00000010.
REQ-030 Start accepted with 0x1+0x2, second start pulse with 0xF0000000+0xF0000000 during RUN -> ignored, sum=0x00000003, single done pulse.
REQ-031 reset asserted at the 4th RUN cycle -> busy, done, sum, co all 0 immediately (before next clk edge); no done; following op 0xA+0x5 -> sum=0x0000000F.
REQ-032 CLA_SEQ8_SUB_EN defined: 5-7, sub=1 -> sum=0xFFFFFFFE, co=0; 7-5 -> sum=0x00000002, co=1; sub=0 with 7+5 -> sum=0x0000000C.
